// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// state encoding, default watchdog limit and the abort data word.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    localparam int          DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog: counts granted cycles without a memory ack and flags
// the cycle whose increment would reach the limit.
module arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  MAX  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != MAX) begin
            count <= count + 1'b1;
        end
    end

    // Firing one increment early makes the abort edge the one that reaches TIMEOUT.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties; every access is bounded by a watchdog that returns ERR_DATA.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = DEF_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o,
    output arb_state_e        state_o
);

    arb_state_e state;
    logic       granted;
    logic       wd_expired;

    assign granted = (state == GRANT_I) || (state == GRANT_D);
    assign state_o = state;
    assign stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state == IDLE),
        .enable  (granted && !mem_ack_i),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req_i) begin
                        state       <= GRANT_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                    end else if (if_req_i) begin
                        state       <= GRANT_I;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // A real ack in the expiry cycle wins over the abort.
                    if (mem_ack_i || wd_expired) begin
                        state     <= DONE;
                        mem_req_o <= 1'b0;
                        if (!mem_ack_i) err_o <= 1'b1;
                        if (state == GRANT_I) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_ack_i ? mem_rdata_i : ERR_DATA;
                        end else begin
                            d_ack_o   <= 1'b1;
                            d_rdata_o <= mem_ack_i ? mem_rdata_i : ERR_DATA;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory responder with
// programmable wait states and a cycle-accurate walk through each scenario.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk, rst_n;
    logic        if_req, if_ack, d_req, d_we, d_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack, stall, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    arb_state_e  state;

    int errors = 0;
    int checks = 0;

    // memory responder controls and bus monitor counters
    int mem_wait = 0;
    bit mem_mute = 0;
    int wcnt     = 0;
    int n_if_ack = 0, n_d_ack = 0, n_both = 0, n_req_rise = 0;
    logic mem_req_q = 1'b0;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_ack_o(d_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .stall_o(stall), .err_o(err), .state_o(state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory responder: acks after mem_wait cycles of mem_req
    always @(negedge clk) begin
        if (mem_req && !mem_ack && !mem_mute) begin
            if (wcnt == mem_wait) begin
                mem_ack = 1'b1;
                wcnt    = 0;
            end else begin
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            if (!mem_req) wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (if_ack) n_if_ack++;
        if (d_ack) n_d_ack++;
        if (if_ack && d_ack) n_both++;
        if (mem_req && !mem_req_q) n_req_rise++;
        mem_req_q = mem_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if_ack(input int budget);
        int n = 0;
        while (!if_ack && n < budget) begin
            step();
            n++;
        end
        check("if_ack_within_budget", 32'(if_ack), 32'h1);
    endtask

    initial begin
        int s_if, s_d, s_both, s_rise;
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        step();
        step();
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_acks", 32'({if_ack, d_ack, mem_we, err}), 32'h0);
        check("rst_regs", mem_addr | mem_wdata | if_rdata | d_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // single load, ack one cycle after grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'h1234; mem_wait = 0;
        #1;
        check("load_stall_pre", 32'(stall), 32'h1);
        step();
        check("load_mem_req", 32'(mem_req), 32'h1);
        check("load_mem_addr", mem_addr, 32'h40);
        check("load_mem_we", 32'(mem_we), 32'h0);
        check("load_stall_wait", 32'(stall), 32'h1);
        check("load_no_early_ack", 32'(d_ack), 32'h0);
        step();
        check("load_ack", 32'(d_ack), 32'h1);
        check("load_rdata", d_rdata, 32'h1234);
        check("load_stall_ack", 32'(stall), 32'h0);
        check("load_req_dropped", 32'(mem_req), 32'h0);
        step();
        d_req = 1'b0;
        check("load_ack_one_pulse", 32'(d_ack), 32'h0);
        step();

        // simultaneous store + fetch: store first, fetch after DONE
        s_if = n_if_ack; s_d = n_d_ack; s_both = n_both; s_rise = n_req_rise;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hAA; mem_rdata = 32'h5555;
        step();
        check("sim_store_we", 32'(mem_we), 32'h1);
        check("sim_store_wdata", mem_wdata, 32'hAA);
        check("sim_store_addr", mem_addr, 32'h80);
        step();
        check("sim_d_ack", 32'(d_ack), 32'h1);
        check("sim_if_not_yet", 32'(if_ack), 32'h0);
        step();
        d_req = 1'b0; d_we = 1'b0;
        check("sim_done_idle", 32'(mem_req), 32'h0);
        check("sim_fetch_stall", 32'(stall), 32'h1);
        step();
        check("sim_fetch_req", 32'(mem_req), 32'h1);
        check("sim_fetch_addr", mem_addr, 32'h100);
        check("sim_fetch_we", 32'(mem_we), 32'h0);
        step();
        check("sim_if_ack", 32'(if_ack), 32'h1);
        check("sim_if_rdata", if_rdata, 32'h5555);
        // fetch request still high through the ack cycle must not be re-granted
        step();
        if_req = 1'b0;
        step(); step(); step();
        check("held_no_regrant", 32'(mem_req), 32'h0);
        check("held_if_ack_count", 32'(n_if_ack - s_if), 32'h1);
        check("sim_d_ack_count", 32'(n_d_ack - s_d), 32'h1);
        check("sim_never_both", 32'(n_both - s_both), 32'h0);
        check("sim_req_rises", 32'(n_req_rise - s_rise), 32'h2);

        // timeout: memory never acks
        mem_mute = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        step();
        check("to_req_first", 32'(mem_req), 32'h1);
        for (int i = 0; i < 15; i++) step();
        check("to_req_cycle16", 32'(mem_req), 32'h1);
        check("to_no_ack_yet", 32'(d_ack), 32'h0);
        check("to_no_err_yet", 32'(err), 32'h0);
        step();
        check("to_req_dropped", 32'(mem_req), 32'h0);
        check("to_ack", 32'(d_ack), 32'h1);
        check("to_err_data", d_rdata, 32'hDEADBEEF);
        check("to_err_set", 32'(err), 32'h1);
        step();
        d_req = 1'b0; mem_mute = 1'b0;
        step();
        // err is sticky across a later good access
        if_req = 1'b1; if_addr = 32'h180; mem_rdata = 32'h0BAD_F00D; mem_wait = 1;
        step();
        wait_if_ack(20);
        check("to_next_rdata", if_rdata, 32'h0BAD_F00D);
        check("to_err_sticky", 32'(err), 32'h1);
        step();
        if_req = 1'b0;
        step();

        // reset in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h200; mem_wait = 5;
        step();
        check("rm_in_grant_i", 32'(state), 32'(GRANT_I));
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_mem_req_async", 32'(mem_req), 32'h0);
        check("rm_if_ack_async", 32'(if_ack), 32'h0);
        check("rm_err_async", 32'(err), 32'h0);
        check("rm_state_async", 32'(state), 32'(IDLE));
        if_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rm_idle_after", 32'(state), 32'(IDLE));
        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h3333; mem_wait = 2;
        step();
        wait_if_ack(20);
        check("rm_new_fetch_rdata", if_rdata, 32'h3333);
        check("rm_new_fetch_err", 32'(err), 32'h0);
        step();
        if_req = 1'b0;
        step();

        // five wait states: request and address stable for six cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; mem_rdata = 32'h6060; mem_wait = 5;
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("ws_req_c%0d", c), 32'(mem_req), 32'h1);
            check($sformatf("ws_addr_c%0d", c), mem_addr, 32'h60);
        end
        step();
        check("ws_ack_c7", 32'(d_ack), 32'h1);
        check("ws_rdata", d_rdata, 32'h6060);
        check("ws_no_err", 32'(err), 32'h0);
        step();
        d_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
